// File: rtl/event_pop_reader.sv
// event_pop_reader
//   Pop-side reader for the DVS event input FIFO. It drains buffered events
//   through the FIFO's pop/empty interface. Events with coordinates outside
//   the sensor are dropped. Accepted events are registered together with the
//   timestamp delta to the previous accepted event and presented on a
//   valid/ready stream. Enable/flush control and saturating event and drop
//   counters are also provided.
//
// Ports
//   clk, rst       clock (posedge) and asynchronous active-high reset
//   enable         1 = drain the FIFO while running
//   flush          1-cycle pulse: discard everything buffered in the FIFO
//   fifo_empty     FIFO empty flag
//   fifo_x/y/pol/ts head-of-FIFO event (valid while !fifo_empty)
//   fifo_pop       pop request to the FIFO (combinational)
//   out_valid      output event valid
//   out_ready      downstream accept
//   out_x/y/pol/ts registered event fields
//   out_dt         out_ts minus previous accepted ts (mod 2^16), 0 if first
//   out_first      first event since reset or since a flush completed
//   busy           controller not idle
//   evt_cnt        events loaded to the output, saturating
//   drop_cnt       out-of-range events popped and dropped, saturating
module event_pop_reader #(
  parameter int SENSOR_W = 320,
  parameter int SENSOR_H = 320,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             flush,
  input  logic             fifo_empty,
  input  logic [8:0]       fifo_x,
  input  logic [8:0]       fifo_y,
  input  logic             fifo_pol,
  input  logic [15:0]      fifo_ts,
  output logic             fifo_pop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [8:0]       out_x,
  output logic [8:0]       out_y,
  output logic             out_pol,
  output logic [15:0]      out_ts,
  output logic [15:0]      out_dt,
  output logic             out_first,
  output logic             busy,
  output logic [CNT_W-1:0] evt_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        first_armed;
  logic [15:0] last_ts;
  logic        in_range;
  logic        load_p0;
  logic        drop_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Delta wraps naturally in 16 bits; the first event after reset/flush has
  // no predecessor, so its delta is forced to zero.
  function automatic logic [15:0] ts_delta(input logic [15:0] cur,
                                           input logic [15:0] prev,
                                           input logic        first);
    if (first) return 16'd0;
    return cur - prev;
  endfunction

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    case (state)
      IDLE: begin
        if (flush)       state_nxt = FLUSH;
        else if (enable) state_nxt = RUN;
      end
      RUN: begin
        // Pop only when the output register is free or being emptied now.
        fifo_pop = !fifo_empty && (!out_valid || out_ready);
        if (flush)        state_nxt = FLUSH;
        else if (!enable) state_nxt = IDLE;
      end
      FLUSH: begin
        fifo_pop = !fifo_empty;
        if (fifo_empty) state_nxt = enable ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_range = (int'(fifo_x) < SENSOR_W) && (int'(fifo_y) < SENSOR_H);
  // Pops made while flushing are discarded and never counted.
  assign load_p0  = (state == RUN) && fifo_pop && in_range;
  assign drop_p0  = (state == RUN) && fifo_pop && !in_range;
  assign busy     = (state != IDLE);

  // ---- stage boundary: popped head -> registered output ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      first_armed <= 1'b1;
      last_ts     <= 16'd0;
      evt_cnt     <= '0;
      drop_cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (load_p0)        out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      if (load_p0) begin
        first_armed <= 1'b0;
        last_ts     <= fifo_ts;
        evt_cnt     <= sat_inc(evt_cnt);
      end else if (state == FLUSH) begin
        first_armed <= 1'b1;
      end
      if (drop_p0) drop_cnt <= sat_inc(drop_cnt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_x     <= 9'd0;
      out_y     <= 9'd0;
      out_pol   <= 1'b0;
      out_ts    <= 16'd0;
      out_dt    <= 16'd0;
      out_first <= 1'b0;
    end else if (load_p0) begin
      out_x     <= fifo_x;
      out_y     <= fifo_y;
      out_pol   <= fifo_pol;
      out_ts    <= fifo_ts;
      out_dt    <= ts_delta(fifo_ts, last_ts, first_armed);
      out_first <= first_armed;
    end
  end

endmodule
